// File: rtl/data_bus_responder_if.sv
// rtl/data_bus_responder_if.sv - CPU data bus signals between CPU (master) and responder (slave)
interface data_bus_responder_if;
  logic [13:0] address;
  logic [31:0] wrData;
  logic        wrEn;
  logic [31:0] rdData;

  modport master (output address, wrData, wrEn, input rdData);
  modport slave  (input address, wrData, wrEn, output rdData);
endinterface

// File: rtl/data_bus_responder.sv
// rtl/data_bus_responder.sv - data RAM plus LED/switch/cycle/timer/status I/O registers
// Optional DATA_BUS_ERR_EN: busErr pulse and ERRADDR capture register at IO_BASE+5.
module data_bus_responder #(
  parameter int          DEPTH   = 4096,
  parameter logic [13:0] IO_BASE = 14'h3F00
) (
  input  logic                 clk,
  input  logic                 nRst,
  data_bus_responder_if.slave  bus,
  output logic [7:0]           leds,
  input  logic [7:0]           switches,
  output logic                 timerIrq,
  output logic                 busErr
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, RUN} timerState_t;

  logic [31:0] ram [DEPTH];
  logic [AW-1:0] ramIdx;
  logic [7:0]  ledReg, swMeta, swSync;
  logic [31:0] cycleCnt, timerCnt, timerNext, readVal;
  logic        expired, irqEn, expireEvt;
  logic        isRam, isLed, isSw, isCyc, isTmr, isSts;
  logic        wrLed, wrCyc, wrTmr, wrSts;
  timerState_t state, stateNext;

  always_comb begin
    isRam  = 32'(bus.address) < DEPTH;
    ramIdx = bus.address[AW-1:0];
    isLed  = bus.address == IO_BASE;
    isSw   = bus.address == IO_BASE + 14'd1;
    isCyc  = bus.address == IO_BASE + 14'd2;
    isTmr  = bus.address == IO_BASE + 14'd3;
    isSts  = bus.address == IO_BASE + 14'd4;
    wrLed  = bus.wrEn & isLed;
    wrCyc  = bus.wrEn & isCyc;
    wrTmr  = bus.wrEn & isTmr;
    wrSts  = bus.wrEn & isSts;
  end

  // A CPU write always wins over the countdown, so writing 0 on the last step suppresses expiry.
  always_comb begin
    stateNext = state;
    timerNext = timerCnt;
    expireEvt = 1'b0;
    case (state)
      IDLE: begin
        if (wrTmr && bus.wrData != 32'd0) begin
          stateNext = RUN;
          timerNext = bus.wrData;
        end
      end
      RUN: begin
        if (wrTmr) begin
          timerNext = bus.wrData;
          if (bus.wrData == 32'd0) stateNext = IDLE;
        end else begin
          timerNext = timerCnt - 32'd1;
          if (timerCnt == 32'd1) begin
            stateNext = IDLE;
            expireEvt = 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      state    <= IDLE;
      timerCnt <= 32'd0;
    end else begin
      state    <= stateNext;
      timerCnt <= timerNext;
    end
  end

`ifdef DATA_BUS_ERR_EN
  logic        isErr, unmapped, errValid, busErrQ;
  logic [13:0] errAddr;

  always_comb begin
    isErr    = bus.address == IO_BASE + 14'd5;
    unmapped = !(isRam | isLed | isSw | isCyc | isTmr | isSts | isErr);
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      busErrQ  <= 1'b0;
      errValid <= 1'b0;
      errAddr  <= 14'd0;
    end else begin
      busErrQ <= unmapped;
      if (bus.wrEn && isErr) begin
        errValid <= 1'b0;
        errAddr  <= 14'd0;
      end else if (unmapped && !errValid) begin
        errValid <= 1'b1;
        errAddr  <= bus.address;
      end
    end
  end

  assign busErr = busErrQ;
`else
  assign busErr = 1'b0;
`endif

  always_comb begin
    readVal = 32'd0;
    if (isRam)      readVal = ram[ramIdx];
    else if (isLed) readVal = {24'd0, ledReg};
    else if (isSw)  readVal = {24'd0, swSync};
    else if (isCyc) readVal = cycleCnt;
    else if (isTmr) readVal = timerCnt;
    else if (isSts) readVal = {30'd0, irqEn, expired};
`ifdef DATA_BUS_ERR_EN
    else if (isErr) readVal = {errValid, 17'd0, errAddr};
`endif
  end

  // RAM has no reset, but writes are still blocked while reset is held.
  always_ff @(posedge clk) begin
    if (!nRst && bus.wrEn && isRam) ram[ramIdx] <= bus.wrData;
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      bus.rdData <= 32'd0;
      ledReg     <= 8'd0;
      swMeta     <= 8'd0;
      swSync     <= 8'd0;
      cycleCnt   <= 32'd0;
      expired    <= 1'b0;
      irqEn      <= 1'b0;
    end else begin
      bus.rdData <= readVal;
      swMeta     <= switches;
      swSync     <= swMeta;
      cycleCnt   <= wrCyc ? 32'd0 : cycleCnt + 32'd1;
      if (wrLed) ledReg <= bus.wrData[7:0];
      if (expireEvt)                  expired <= 1'b1;
      else if (wrSts && bus.wrData[0]) expired <= 1'b0;
      if (wrSts) irqEn <= bus.wrData[1];
    end
  end

  assign leds     = ledReg;
  assign timerIrq = expired & irqEn;
endmodule

// File: tb/tb_data_bus_responder.sv
// tb/tb_data_bus_responder.sv - directed and random checks of data_bus_responder against a register-map model
module tb_data_bus_responder;
  localparam int          DEPTH   = 4096;
  localparam logic [13:0] IO_BASE = 14'h3F00;
  localparam logic [13:0] A_LED = IO_BASE, A_SW = IO_BASE + 14'd1, A_CYC = IO_BASE + 14'd2;
  localparam logic [13:0] A_TMR = IO_BASE + 14'd3, A_STS = IO_BASE + 14'd4, A_ERR = IO_BASE + 14'd5;

  logic       clk = 1'b0;
  logic       nRst;
  logic [7:0] leds, switches;
  logic       timerIrq, busErr;

  data_bus_responder_if bus ();

  data_bus_responder #(.DEPTH(DEPTH), .IO_BASE(IO_BASE)) dut (
    .clk(clk), .nRst(nRst), .bus(bus), .leds(leds),
    .switches(switches), .timerIrq(timerIrq), .busErr(busErr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mRam [int];
  logic [7:0]  mLed, mSw1, mSw2;
  logic [31:0] mCycle, mTimer;
  logic        mExp, mIrqEn, mErrV, mBusErr;
  logic [13:0] mErrA;
  logic [31:0] lastRd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // 0 RAM, 1 LED, 2 SWITCH, 3 CYCLE, 4 TIMER, 5 STATUS, 6 ERRADDR, -1 unmapped
  function automatic int regOf(input logic [13:0] a);
    int off;
    if (int'(a) < DEPTH) return 0;
    if (a < IO_BASE) return -1;
    off = int'(a - IO_BASE);
    if (off <= 4) return off + 1;
`ifdef DATA_BUS_ERR_EN
    if (off == 5) return 6;
`endif
    return -1;
  endfunction

  function automatic logic [31:0] modelRead(input logic [13:0] a);
    case (regOf(a))
      0: return mRam[int'(a)];
      1: return {24'd0, mLed};
      2: return {24'd0, mSw2};
      3: return mCycle;
      4: return mTimer;
      5: return {30'd0, mIrqEn, mExp};
      6: return {mErrV, 17'd0, mErrA};
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkOutputs(input logic [31:0] expRd);
    lastRd = bus.rdData;
    chk("rdData", bus.rdData, expRd);
    chk("leds", {24'd0, leds}, {24'd0, mLed});
    chk("timerIrq", {31'd0, timerIrq}, {31'd0, mExp & mIrqEn});
    chk("busErr", {31'd0, busErr}, {31'd0, mBusErr});
  endtask

  task automatic step(input logic [13:0] a, input logic [31:0] d, input logic we);
    logic [31:0] expRd;
    int          r;
    logic        fire;
    bus.address = a;
    bus.wrData  = d;
    bus.wrEn    = we;
    r     = regOf(a);
    expRd = modelRead(a);
    fire  = 1'b0;
    if (we && r == 4) mTimer = d;
    else if (mTimer != 0) begin
      mTimer = mTimer - 1;
      fire = (mTimer == 0);
    end
    mCycle = (we && r == 3) ? 32'd0 : mCycle + 32'd1;
    if (we && r == 5) begin
      mIrqEn = d[1];
      if (d[0]) mExp = 1'b0;
    end
    if (fire) mExp = 1'b1;
    if (we && r == 0) mRam[int'(a)] = d;
    if (we && r == 1) mLed = d[7:0];
    mSw2 = mSw1;
    mSw1 = switches;
`ifdef DATA_BUS_ERR_EN
    mBusErr = (r == -1);
    if (we && r == 6) begin
      mErrV = 1'b0;
      mErrA = 14'd0;
    end else if (r == -1 && !mErrV) begin
      mErrV = 1'b1;
      mErrA = a;
    end
`else
    mBusErr = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
    checkOutputs(expRd);
  endtask

  task automatic doReset(input logic [13:0] a, input logic [31:0] d, input logic we);
    nRst        = 1'b1;
    bus.address = a;
    bus.wrData  = d;
    bus.wrEn    = we;
    mLed = 8'd0; mSw1 = 8'd0; mSw2 = 8'd0; mCycle = 32'd0; mTimer = 32'd0;
    mExp = 1'b0; mIrqEn = 1'b0; mErrV = 1'b0; mErrA = 14'd0; mBusErr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutputs(32'd0);
    nRst = 1'b0;
  endtask

  initial begin
    logic [31:0] c0, c1;
    logic [13:0] a;
    logic [31:0] d;
    int          k;
    switches    = 8'd0;
    bus.address = 14'd0;
    bus.wrData  = 32'd0;
    bus.wrEn    = 1'b0;
    @(negedge clk);
    doReset(14'd0, 32'd0, 1'b0);
    step(A_TMR, 32'd0, 1'b0);
    for (int i = 0; i < 32; i++) step(14'(i), $urandom, 1'b1);
    step(14'(DEPTH - 1), $urandom, 1'b1);

    // RAM read latency and read-before-write
    step(14'h010, 32'hDEADBEEF, 1'b1);
    step(14'h010, 32'd0, 1'b0);
    chk("ram_read", lastRd, 32'hDEADBEEF);
    step(14'h010, 32'h1, 1'b1);
    chk("ram_rbw", lastRd, 32'hDEADBEEF);
    step(14'h010, 32'd0, 1'b0);

    // LEDs and synchronised switches
    step(A_LED, 32'h1A5, 1'b1);
    chk("leds_a5", {24'd0, leds}, 32'hA5);
    step(A_LED, 32'd0, 1'b0);
    chk("led_read", lastRd, 32'hA5);
    switches = 8'h3C;
    step(A_SW, 32'd0, 1'b0);
    step(A_SW, 32'd0, 1'b0);
    step(A_SW, 32'd0, 1'b0);
    chk("switch_sync", lastRd, 32'h3C);

    // Timer expiry, interrupt, clear, and expiry-beats-clear
    step(A_STS, 32'h2, 1'b1);
    step(A_TMR, 32'd3, 1'b1);
    step(A_STS, 32'd0, 1'b0);
    step(A_STS, 32'd0, 1'b0);
    chk("irq_early", {31'd0, timerIrq}, 32'd0);
    step(A_STS, 32'd0, 1'b0);
    chk("irq_at3", {31'd0, timerIrq}, 32'd1);
    step(A_STS, 32'h3, 1'b1);
    chk("irq_clear", {31'd0, timerIrq}, 32'd0);
    step(A_TMR, 32'd2, 1'b1);
    step(A_STS, 32'd0, 1'b0);
    step(A_STS, 32'h3, 1'b1);
    chk("set_beats_clear", {31'd0, timerIrq}, 32'd1);
    step(A_STS, 32'h1, 1'b1);

    // Writing 0 stops the timer without expiry
    step(A_TMR, 32'd5, 1'b1);
    step(A_TMR, 32'd0, 1'b0);
    step(A_TMR, 32'd0, 1'b0);
    step(A_TMR, 32'd0, 1'b1);
    step(A_TMR, 32'd0, 1'b0);
    chk("timer_stopped", lastRd, 32'd0);
    for (int i = 0; i < 6; i++) step(A_STS, 32'd0, 1'b0);
    chk("no_expiry", lastRd & 32'h1, 32'd0);

    // Cycle counter spacing, clear and wrap
    step(A_CYC, 32'd0, 1'b0);
    c0 = lastRd;
    for (int i = 0; i < 3; i++) step(A_LED, 32'd0, 1'b0);
    step(A_CYC, 32'd0, 1'b0);
    c1 = lastRd;
    chk("cycle_delta", c1 - c0, 32'd4);
    step(A_CYC, 32'h1234, 1'b1);
    step(A_LED, 32'd0, 1'b0);
    step(A_CYC, 32'd0, 1'b0);
    chk("cycle_after_clear", lastRd, 32'd1);
    force dut.cycleCnt = 32'hFFFF_FFFF;
    #1 release dut.cycleCnt;
    mCycle = 32'hFFFF_FFFF;
    step(A_CYC, 32'd0, 1'b0);
    chk("cycle_max", lastRd, 32'hFFFF_FFFF);
    step(A_CYC, 32'd0, 1'b0);
    chk("cycle_wrap", lastRd, 32'd0);

    // Unmapped access and error capture
    step(14'h2000, 32'd0, 1'b0);
    chk("unmapped_read", lastRd, 32'd0);
    step(14'h3000, 32'h55, 1'b1);
    step(A_ERR, 32'd0, 1'b0);
`ifdef DATA_BUS_ERR_EN
    chk("erraddr_first", lastRd, 32'h8000_2000);
    step(A_ERR, 32'd0, 1'b1);
    step(A_ERR, 32'd0, 1'b0);
    chk("erraddr_cleared", lastRd, 32'd0);
`else
    chk("erraddr_unmapped", lastRd, 32'd0);
`endif

    // Mid-run reset aborts the timer and drops the concurrent write
    step(A_STS, 32'h2, 1'b1);
    step(A_TMR, 32'd20, 1'b1);
    step(A_LED, 32'h77, 1'b1);
    doReset(14'h010, 32'hBAD0BAD0, 1'b1);
    step(14'h010, 32'd0, 1'b0);
    chk("ram_after_reset", lastRd, 32'h1);
    step(A_TMR, 32'd0, 1'b0);
    chk("timer_after_reset", lastRd, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 9);
      if (k < 3)      a = 14'($urandom_range(0, 31));
      else if (k < 8) a = IO_BASE + 14'($urandom_range(0, 6));
      else if (k < 9) a = 14'(DEPTH - 1);
      else            a = 14'($urandom_range(DEPTH, 16383));
      d = $urandom;
      if (a == A_TMR) d = 32'($urandom_range(0, 6));
      if (a == A_CYC && $urandom_range(0, 3) != 0) d = 32'd0;
      if ($urandom_range(0, 15) == 0) switches = 8'($urandom);
      step(a, d, ($urandom_range(0, 2) == 0) && !(a == A_CYC && d == 32'd0 && $urandom_range(0, 1) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
